// File: rtl/seven_segment_pkg.sv
// Shared types and hex-to-segment decode for the 7-segment scan driver.
package seven_segment_pkg;

  typedef struct packed {
    logic       enable;
    logic       dp;
    logic [3:0] value;
  } digit_t;

  // Segment patterns in {g,f,e,d,c,b,a} order, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] hex_to_segments(input logic [3:0] value);
    logic [6:0] seg;
    seg = SEG_0;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_pwm_scanner.sv
// Slot/digit/frame/PWM timebase for the scan driver; produces the per-clock
// lit decision for the digit currently being scanned.
module seven_segment_pwm_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUMBER_OF_DIGITS = 6,
  parameter int SCAN_DIVIDER     = 1000,
  parameter int GUARD_CYCLES     = 2,
  parameter int BRIGHTNESS_BITS  = 4,
  parameter int BLINK_FRAMES     = 64,
  localparam int IDX_W   = index_width(NUMBER_OF_DIGITS),
  localparam int SLOT_W  = index_width(SCAN_DIVIDER),
  localparam int FRAME_W = index_width(BLINK_FRAMES)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUMBER_OF_DIGITS-1:0] enable,
  input  logic [BRIGHTNESS_BITS-1:0]  brightness,
  input  logic [NUMBER_OF_DIGITS-1:0] blink_mask,
  output logic [IDX_W-1:0]            digit_idx,
  output logic                        frame_end,
  output logic                        lit,
  output logic                        frame_start
);

  logic [SLOT_W-1:0]          slot_cnt;
  logic [FRAME_W-1:0]         frame_cnt;
  logic [BRIGHTNESS_BITS-1:0] pwm_cnt;
  logic                       blink_phase;
  logic                       slot_wrap;
  logic                       digit_wrap;

  assign slot_wrap  = (slot_cnt == SLOT_W'(SCAN_DIVIDER - 1));
  assign digit_wrap = (digit_idx == IDX_W'(NUMBER_OF_DIGITS - 1));
  assign frame_end  = slot_wrap && digit_wrap;

  // The first GUARD_CYCLES of every slot stay dark so the previous digit's
  // segments never ghost onto the newly selected one.
  assign lit = enable[digit_idx]
            && (slot_cnt >= SLOT_W'(GUARD_CYCLES))
            && (pwm_cnt < brightness)
            && !(blink_mask[digit_idx] && blink_phase);

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      pwm_cnt     <= '0;
      blink_phase <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      frame_start <= (slot_cnt == '0) && (digit_idx == '0);
      if (slot_wrap) begin
        slot_cnt <= '0;
        if (digit_wrap) begin
          digit_idx <= '0;
          if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed 7-segment driver: frame-synchronous digit shadow, decode and pin polarity.
// Define SEVEN_SEGMENT_LZB_EN to blank leading zero digits.
module seven_segment_scan_driver
  import seven_segment_pkg::*;
#(
  parameter int   NUMBER_OF_DIGITS = 6,
  parameter logic CATHODE_COMMON   = 1'b1,
  parameter int   SCAN_DIVIDER     = 1000,
  parameter int   GUARD_CYCLES     = 2,
  parameter int   BRIGHTNESS_BITS  = 4,
  parameter int   BLINK_FRAMES     = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  digit_t                      digits [0:NUMBER_OF_DIGITS-1],
  input  logic                        update,
  input  logic [BRIGHTNESS_BITS-1:0]  brightness,
  input  logic [NUMBER_OF_DIGITS-1:0] blink_mask,
  output logic [7:0]                  segment_out,
  output logic [NUMBER_OF_DIGITS-1:0] digit_selector_out,
  output logic                        frame_start
);

  localparam int IDX_W = index_width(NUMBER_OF_DIGITS);

  digit_t                      pending [0:NUMBER_OF_DIGITS-1];
  digit_t                      active  [0:NUMBER_OF_DIGITS-1];
  logic                        pending_valid;
  logic [NUMBER_OF_DIGITS-1:0] shown_en;
  logic [IDX_W-1:0]            digit_idx;
  logic                        frame_end;
  logic                        lit;
  digit_t                      cur;
  logic [7:0]                  seg_on;
  logic [NUMBER_OF_DIGITS-1:0] sel_on;
`ifdef SEVEN_SEGMENT_LZB_EN
  logic                        leading;
`endif

  // Displayed digits only change at the frame boundary so a frame never tears.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
      pending_valid <= 1'b0;
    end else begin
      if (update) pending <= digits;
      if (frame_end) begin
        pending_valid <= 1'b0;
        if (update) active <= digits;
        else if (pending_valid) active <= pending;
      end else if (update) begin
        pending_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    shown_en = '0;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) shown_en[i] = active[i].enable;
`ifdef SEVEN_SEGMENT_LZB_EN
    leading = 1'b1;
    for (int i = NUMBER_OF_DIGITS - 1; i >= 1; i--) begin
      if (active[i].enable) begin
        if (leading && (active[i].value == 4'd0) && !active[i].dp) shown_en[i] = 1'b0;
        else leading = 1'b0;
      end
    end
`endif
  end

  seven_segment_pwm_scanner #(
    .NUMBER_OF_DIGITS(NUMBER_OF_DIGITS),
    .SCAN_DIVIDER    (SCAN_DIVIDER),
    .GUARD_CYCLES    (GUARD_CYCLES),
    .BRIGHTNESS_BITS (BRIGHTNESS_BITS),
    .BLINK_FRAMES    (BLINK_FRAMES)
  ) scanner (
    .clock      (clock),
    .reset      (reset),
    .enable     (shown_en),
    .brightness (brightness),
    .blink_mask (blink_mask),
    .digit_idx  (digit_idx),
    .frame_end  (frame_end),
    .lit        (lit),
    .frame_start(frame_start)
  );

  assign cur = active[digit_idx];

  always_ff @(posedge clock) begin
    if (reset || !lit) begin
      seg_on <= '0;
      sel_on <= '0;
    end else begin
      seg_on <= {cur.dp, hex_to_segments(cur.value)};
      sel_on <= NUMBER_OF_DIGITS'(1) << digit_idx;
    end
  end

  assign segment_out        = CATHODE_COMMON ? seg_on : ~seg_on;
  assign digit_selector_out = CATHODE_COMMON ? ~sel_on : sel_on;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench: directed schedule pushes per-clock expectations, a monitor
// pops and compares both a common-cathode and a common-anode instance.
`timescale 1ns/1ps
module tb_seven_segment_scan_driver;
  import seven_segment_pkg::*;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 1;
  localparam int BB    = 2;
  localparam int BF    = 2;
  localparam int FRAME = DIV * N;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          update = 1'b0;
  digit_t        digits [0:N-1];
  logic [BB-1:0] brightness = '0;
  logic [N-1:0]  blink_mask = '0;
  logic [7:0]    seg_c, seg_a;
  logic [N-1:0]  sel_c, sel_a;
  logic          fs_c, fs_a;

  always #5 clock = ~clock;

  seven_segment_scan_driver #(
    .NUMBER_OF_DIGITS(N), .CATHODE_COMMON(1'b1), .SCAN_DIVIDER(DIV),
    .GUARD_CYCLES(GUARD), .BRIGHTNESS_BITS(BB), .BLINK_FRAMES(BF)
  ) dut_c (
    .clock(clock), .reset(reset), .digits(digits), .update(update),
    .brightness(brightness), .blink_mask(blink_mask),
    .segment_out(seg_c), .digit_selector_out(sel_c), .frame_start(fs_c)
  );

  seven_segment_scan_driver #(
    .NUMBER_OF_DIGITS(N), .CATHODE_COMMON(1'b0), .SCAN_DIVIDER(DIV),
    .GUARD_CYCLES(GUARD), .BRIGHTNESS_BITS(BB), .BLINK_FRAMES(BF)
  ) dut_a (
    .clock(clock), .reset(reset), .digits(digits), .update(update),
    .brightness(brightness), .blink_mask(blink_mask),
    .segment_out(seg_a), .digit_selector_out(sel_a), .frame_start(fs_a)
  );

  typedef struct {
    logic [7:0]   seg;
    logic [N-1:0] sel;
    logic         fs;
    int           tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  digit_t m_active  [0:N-1];
  digit_t m_pending [0:N-1];
  logic   m_pv = 1'b0;
  int     t = 0;

  function automatic digit_t mk(input logic en, input logic dp, input logic [3:0] val);
    digit_t d;
    d.enable = en;
    d.dp     = dp;
    d.value  = val;
    return d;
  endfunction

  task automatic fill(input logic [3:0] val);
    for (int i = 0; i < N; i++) digits[i] = mk(1'b1, 1'b0, val);
  endtask

  // Expected pins for the edge that closes the current cycle, from absolute time t.
  task automatic push_expected();
    exp_t         e;
    int           slot, idx, frame, pwm;
    logic         phase, lit;
    logic [N-1:0] en, one_hot;
    e.tag = t;
    e.seg = 8'h00;
    e.sel = '1;
    e.fs  = 1'b0;
    if (!reset) begin
      slot  = t % DIV;
      idx   = (t / DIV) % N;
      frame = t / FRAME;
      pwm   = t % (1 << BB);
      phase = ((frame / BF) % 2) == 1;
      e.fs  = (slot == 0) && (idx == 0);
      for (int i = 0; i < N; i++) en[i] = m_active[i].enable;
`ifdef SEVEN_SEGMENT_LZB_EN
      for (int i = 1; i < N; i++) begin
        logic all_zero;
        all_zero = 1'b1;
        for (int j = i; j < N; j++)
          if (m_active[j].enable && (m_active[j].value != 4'd0 || m_active[j].dp)) all_zero = 1'b0;
        if (all_zero) en[i] = 1'b0;
      end
`endif
      lit = en[idx] && (slot >= GUARD) && (pwm < int'(brightness)) && !(blink_mask[idx] && phase);
      if (lit) begin
        one_hot      = '0;
        one_hot[idx] = 1'b1;
        e.seg = {m_active[idx].dp, dec_tab[m_active[idx].value]};
        e.sel = ~one_hot;
      end
    end
    q.push_back(e);
  endtask

  task automatic cycle();
    logic boundary;
    push_expected();
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_active[i]  = '0;
        m_pending[i] = '0;
      end
      m_pv = 1'b0;
      t    = 0;
    end else begin
      boundary = (t % FRAME) == FRAME - 1;
      if (boundary) begin
        if (update) m_active = digits;
        else if (m_pv) m_active = m_pending;
        m_pv = 1'b0;
      end
      if (update) begin
        m_pending = digits;
        if (!boundary) m_pv = 1'b1;
      end
      t++;
    end
    @(negedge clock);
  endtask

  task automatic schedule();
    update = 1'b0;
    if (t == 0)   begin fill(4'd8); brightness = 2'd3; update = 1'b1; end
    if (t == 66)  begin digits[0] = mk(1'b1, 1'b0, 4'd7); update = 1'b1; end
    if (t == 70)  begin digits[0] = mk(1'b1, 1'b0, 4'd1); update = 1'b1; end
    if (t == 127) begin digits[0] = mk(1'b1, 1'b0, 4'd2); update = 1'b1; end
    if (t == 160) brightness = 2'd0;
    if (t == 192) brightness = 2'd1;
    if (t == 224) begin brightness = 2'd3; blink_mask = 4'b0001; end
    if (t == 352) begin
      blink_mask = '0;
      digits[3] = mk(1'b1, 1'b0, 4'd0);
      digits[2] = mk(1'b1, 1'b0, 4'd0);
      digits[1] = mk(1'b1, 1'b0, 4'd4);
      digits[0] = mk(1'b1, 1'b0, 4'd0);
      update = 1'b1;
    end
    if (t == 384) begin
      digits[3] = mk(1'b1, 1'b0, 4'd0);
      digits[2] = mk(1'b1, 1'b1, 4'd0);
      digits[1] = mk(1'b1, 1'b0, 4'd0);
      digits[0] = mk(1'b1, 1'b0, 4'd0);
      update = 1'b1;
    end
    if (t == 444) begin fill(4'd8); update = 1'b1; end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        vectors++;
        if (seg_c !== mon_e.seg) begin
          miscompares++;
          $display("FAIL seg_cathode t=%0d got %h want %h", mon_e.tag, seg_c, mon_e.seg);
        end
        if (sel_c !== mon_e.sel) begin
          miscompares++;
          $display("FAIL sel_cathode t=%0d got %b want %b", mon_e.tag, sel_c, mon_e.sel);
        end
        if (fs_c !== mon_e.fs) begin
          miscompares++;
          $display("FAIL frame_start t=%0d got %b want %b", mon_e.tag, fs_c, mon_e.fs);
        end
        if (seg_a !== ~mon_e.seg) begin
          miscompares++;
          $display("FAIL seg_anode t=%0d got %h want %h", mon_e.tag, seg_a, ~mon_e.seg);
        end
        if (sel_a !== ~mon_e.sel) begin
          miscompares++;
          $display("FAIL sel_anode t=%0d got %b want %b", mon_e.tag, sel_a, ~mon_e.sel);
        end
        if (fs_a !== mon_e.fs) begin
          miscompares++;
          $display("FAIL frame_start_anode t=%0d got %b want %b", mon_e.tag, fs_a, mon_e.fs);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    fill(4'd0);
    for (int i = 0; i < N; i++) begin
      m_active[i]  = '0;
      m_pending[i] = '0;
    end
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    while (t < 446) begin
      schedule();
      cycle();
    end
    // Reset mid-frame with an update still pending: it must be discarded.
    update = 1'b0;
    reset  = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    while (t < 70) cycle();
    repeat (2) @(negedge clock);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left %0d expected vectors want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_driver.md
# seven_segment_scan_driver

Self-timed, parametrised multiplexed 7-segment display driver with decimal point, tear-free frame-synchronous digit update, PWM brightness, per-digit blinking and an anti-ghosting guard band. Sits between the user logic producing per-digit codes and the Pmod 7-segment pins. Needs no external `next_segment` strobe: it derives the scan rate from `clock`.

## Interface
Parameters:
- `NUMBER_OF_DIGITS`, 6, digits scanned (≥1); index 0 is least significant / rightmost.
- `CATHODE_COMMON`, 1'b1, 1: segments active-high, selectors active-low; 0: segments active-low, selectors active-high.
- `SCAN_DIVIDER`, 1000, clocks per digit slot (≥ `GUARD_CYCLES`+2).
- `GUARD_CYCLES`, 2, dark clocks at start of each slot.
- `BRIGHTNESS_BITS`, 4, width of brightness input.
- `BLINK_FRAMES`, 64, frames per blink half-period (≥1).

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `digits` in `digit_t [0:NUMBER_OF_DIGITS-1]`: bit5 enable, bit4 dp, [3:0] hex value.
- `update` in 1: latch `digits` into pending shadow.
- `brightness` in `BRIGHTNESS_BITS`: 0 = dark, all-ones = max.
- `blink_mask` in `NUMBER_OF_DIGITS`: 1 = digit blinks.
- `segment_out` out 8: {dp, g..a}, polarity per `CATHODE_COMMON`.
- `digit_selector_out` out `NUMBER_OF_DIGITS`: one-hot active, polarity per `CATHODE_COMMON`.
- `frame_start` out 1: one-clock pulse when digit 0 slot begins.

## Operation
- Counters: `slot_cnt` 0..SCAN_DIVIDER-1; `digit_idx` advances on `slot_cnt` wrap, wraps N-1→0; `frame_cnt` 0..BLINK_FRAMES-1 advances at digit wrap; `blink_phase` toggles on `frame_cnt` wrap; `pwm_cnt` free-running `BRIGHTNESS_BITS`-bit counter.
- Shadow: `update`=1 copies `digits` to `pending`, sets `pending_valid`; multiple updates per frame, last wins. At frame boundary (edge where `digit_idx` goes to 0), `pending_valid` → copy `pending` to `active`, clear flag. `update` on the boundary cycle: its data goes directly to `active`.
- `brightness`, `blink_mask` sampled live, no shadow.
- Lit condition for current digit: `active[idx].enable` && `slot_cnt ≥ GUARD_CYCLES` && `pwm_cnt < brightness` && !(`blink_mask[idx]` && `blink_phase`).
- Lit: selector for `idx` active, segments = {dp, hex decode}. Not lit: all selectors and segments inactive.
- Decode: 0 3F,1 06,2 5B,3 4F,4 66,5 6D,6 7D,7 07,8 7F,9 6F,A 77,b 7C,C 39,d 5E,E 79,F 71 ({g..a}).

## Timing
- Reset: all counters, `active`, `pending`, `pending_valid`, `blink_phase` = 0; `segment_out`/`digit_selector_out` inactive levels (cathode: 8'h00 / all-ones); `frame_start`=0.
- First clock after reset release: `slot_cnt`=0, `digit_idx`=0; `frame_start` pulses on that cycle's registered output.
- Outputs registered: 1-cycle latency from counter state to pins.
- Slot = SCAN_DIVIDER clocks; frame = N×SCAN_DIVIDER; blink period = 2×BLINK_FRAMES frames.
- Reset mid-frame: immediate return to reset state next edge; pending data discarded.

## Configuration
- `SEVEN_SEGMENT_LZB_EN` defined: leading-zero blanking on `active`; enabled digits from index N-1 downward with value 0 and dp=0 are treated as disabled until first nonzero or dp digit; index 0 never blanked.
- Undefined: no suppression; zeros display as "0".

## Structure
- `seven_segment_pkg`: `digit_t` packed struct {enable, dp, value[3:0]}, `SEG_*` decode constants, function `hex_to_segments`.
- Sub-module `seven_segment_pwm_scanner`: slot/digit/frame/pwm counters, `frame_start`, lit gating; top holds shadow, decode, polarity.

## Test plan
Bench params: N=4, SCAN_DIVIDER=8, GUARD_CYCLES=1, BRIGHTNESS_BITS=2, BLINK_FRAMES=2, cathode.
- Reset release, all digits {en=1,dp=0,val=8}, brightness=3, update → from next frame each slot: cycle 0 dark, then `segment_out`=7F with 3-of-4 PWM duty, selector 1110,1101,1011,0111.
- Update mid-frame with digit0 val=1 → old value until next `frame_start`, then 06; update on boundary cycle → new value in that frame.
- brightness=0 → outputs inactive continuously; brightness=1 → lit 1 of 4 clocks.
- blink_mask=0001 → digit 0 dark for 2 frames, lit 2 frames, others unaffected.
- dp=1 val=0 on digit 2 → `segment_out`=BF; `CATHODE_COMMON`=0 build → 40, selector active-high.
- With `SEVEN_SEGMENT_LZB_EN`, digits {0,0,4,0} (idx3..0) → idx3, idx2 dark, idx1 66, idx0 3F; without macro idx3, idx2 3F.
